chunked_serial_adder: RTL and testbench

//  Parametrised multi-cycle adder: computes S = A + B + Cin over WIDTH bits,

---
 rtl/chunked_serial_adder.sv | 152 +++++++++++++++
 tb/tb_chunked_serial_adder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder: S = A + B + Cin over WIDTH bits, CHUNK bits per clock, carry held in a register.
// Optional signed-overflow output V is built when SIGNED_OVF_EN is defined.
module chunked_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
`ifdef SIGNED_OVF_EN
  output logic             V,
`endif
  output logic             Cout
);

  localparam int NCH = (CHUNK > 0) ? WIDTH / CHUNK : 1;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  generate
    if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("chunked_serial_adder: illegal WIDTH/CHUNK combination");
    end
  endgenerate

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            state_r, state_nxt_s;
  logic [WIDTH-1:0]  a_r, b_r, partial_r, s_r;
  logic [WIDTH-1:0]  partial_nxt_s;
  logic [CW-1:0]     cnt_r;
  logic              carry_r, busy_r, done_r, cout_r;
  logic [CHUNK-1:0]  a_chunk_s, b_chunk_s;
  logic [CHUNK:0]    sum_s;
  logic              last_s, accept_s, v_s;
  int                lo_s;

  function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             c);
    return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, c};
  endfunction

  assign last_s   = (cnt_r == CW'(NCH - 1));
  assign accept_s = (state_r == ST_IDLE) && start;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_RUN;
        else       state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (last_s) state_nxt_s = ST_IDLE;
        else        state_nxt_s = ST_RUN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Current chunk sum and partial result including this chunk
  always_comb begin
    lo_s          = int'(cnt_r) * CHUNK;
    a_chunk_s     = CHUNK'(a_r >> lo_s);
    b_chunk_s     = CHUNK'(b_r >> lo_s);
    sum_s         = chunk_add(a_chunk_s, b_chunk_s, carry_r);
    partial_nxt_s = partial_r;
    partial_nxt_s[lo_s +: CHUNK] = sum_s[CHUNK-1:0];
    // Carry into the MSB is recovered from the MSB sum bit of the last chunk.
    v_s = (a_chunk_s[CHUNK-1] ^ b_chunk_s[CHUNK-1] ^ sum_s[CHUNK-1]) ^ sum_s[CHUNK];
  end

  // Operand capture, chunk iteration and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      partial_r <= {WIDTH{1'b0}};
      s_r       <= {WIDTH{1'b0}};
      cnt_r     <= {CW{1'b0}};
      carry_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      cout_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (accept_s) begin
        a_r     <= A;
        b_r     <= B;
        carry_r <= Cin;
        cnt_r   <= {CW{1'b0}};
        busy_r  <= 1'b1;
      end else if (state_r == ST_RUN) begin
        partial_r <= partial_nxt_s;
        carry_r   <= sum_s[CHUNK];
        if (last_s) begin
          cnt_r  <= {CW{1'b0}};
          s_r    <= partial_nxt_s;
          cout_r <= sum_s[CHUNK];
          done_r <= 1'b1;
          busy_r <= 1'b0;
        end else begin
          cnt_r <= cnt_r + CW'(1);
        end
      end else begin
        busy_r <= 1'b0;
      end
    end
  end

`ifdef SIGNED_OVF_EN
  logic v_r;

  // Signed overflow flag, updated together with S/Cout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_r <= 1'b0;
    end else if (state_r == ST_RUN && last_s) begin
      v_r <= v_s;
    end else begin
      v_r <= v_r;
    end
  end

  assign V = v_r;
`else
  logic unused_v_s;
  assign unused_v_s = v_s;
`endif

  assign busy = busy_r;
  assign done = done_r;
  assign S    = s_r;
  assign Cout = cout_r;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Directed-vector bench for chunked_serial_adder (WIDTH=16, CHUNK=4); checks V when SIGNED_OVF_EN is defined.
module tb_chunked_serial_adder;

  localparam int W   = 16;
  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = 16'h0000, B = 16'h0000;
  logic         Cin = 1'b0;
  logic         busy, done, Cout;
  logic [W-1:0] S;
`ifdef SIGNED_OVF_EN
  logic         V;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] prev_s = 16'h0000;

  chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Cin(Cin),
    .busy(busy), .done(done), .S(S),
`ifdef SIGNED_OVF_EN
    .V(V),
`endif
    .Cout(Cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a, b;
    logic         cin;
    logic [W-1:0] s;
    logic         cout, v;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one add, wait for done, verify latency, held S and result.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic [W-1:0] es, input logic ec, input logic ev, input string name);
    int lat;
    A = a; B = b; Cin = cin; start = 1'b1;
    tick();
    start = 1'b0;
    check({name, "_busy_on"}, {31'd0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < 20) begin
      if (S !== prev_s) check({name, "_s_held"}, {16'd0, S}, {16'd0, prev_s});
      if (busy !== 1'b1) check({name, "_busy_hold"}, {31'd0, busy}, 32'd1);
      tick();
      lat++;
    end
    check({name, "_latency"}, lat, LAT);
    check({name, "_s"}, {16'd0, S}, {16'd0, es});
    check({name, "_cout"}, {31'd0, Cout}, {31'd0, ec});
    check({name, "_busy_off"}, {31'd0, busy}, 32'd0);
`ifdef SIGNED_OVF_EN
    check({name, "_v"}, {31'd0, V}, {31'd0, ev});
`else
    if (ev === 1'bx) check({name, "_v_known"}, 32'd0, 32'd1);
`endif
    prev_s = es;
    tick();
    check({name, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [W:0] full;
    logic [W-1:0] ra, rb;
    logic rc, rv;
    int lat;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[4] = '{16'h0005, 16'hFFFB, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[7] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[8] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[9] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};

    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_s", {16'd0, S}, 32'd0);
    check("rst_cout", {31'd0, Cout}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("idle_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].cout, vecs[i].v, $sformatf("vec%0d", i));

    // start held through the busy window and the done edge must be ignored
    A = 16'h1234; B = 16'h4321; Cin = 1'b1; start = 1'b1;
    tick();
    A = 16'h0001; B = 16'h0001; Cin = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    check("ign_latency", lat, LAT);
    check("ign_s", {16'd0, S}, 32'h5556);
    check("ign_busy_at_done", {31'd0, busy}, 32'd0);
    tick();
    start = 1'b0;
    check("ign_next_accept", {31'd0, busy}, 32'd1);
    check("ign_no_second_done", {31'd0, done}, 32'd0);
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    check("ign_next_latency", lat, LAT);
    check("ign_next_s", {16'd0, S}, 32'h0002);
    prev_s = 16'h0002;
    tick();

    // asynchronous reset mid-operation aborts with no later done
    A = 16'hFFFF; B = 16'h0001; Cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_s", {16'd0, S}, 32'd0);
    check("abort_cout", {31'd0, Cout}, 32'd0);
    #1;
    rst = 1'b0;
    lat = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done || busy) lat++;
    end
    check("abort_quiet", lat, 0);
    prev_s = 16'h0000;
    run_op(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, "after_abort");

    // random operands against an arithmetic model
    for (int k = 0; k < 40; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(1, 0));
      full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      rv = (ra[W-1] == rb[W-1]) && (full[W-1] != ra[W-1]);
      run_op(ra, rb, rc, full[W-1:0], full[W], rv, $sformatf("rnd%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
